swap_writer: RTL and testbench
==============================

Name: swap_writer

Overview:
- Memory-side sequencer for the RC4 engine's S-box swap step.
- Reads S[i] and S[j] from the state SRAM, then writes them back crossed: S[i]←old S[j], S[j]←old S[i].
- Drives the SRAM write path and exposes the swapped pair plus the keystream index (S[i]+S[j]) mod 2^DATA_W to the PRGA controller.
- Sits between the RC4 control FSM and the single-port S-box SRAM.

Parameters:
- ADDR_W, 8, S-box address width.
- DATA_W, 8, S-box entry width.
- READ_LAT, 1, SRAM read latency in cycles. Legal range 1..3.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start_i  input  1  request a swap. Sampled only in IDLE.
- idx_i_i  input  ADDR_W  index i. Latched on accepted start.
- idx_j_i  input  ADDR_W  index j. Latched on accepted start.
- busy_o  output  1  high from the cycle after accepted start through DONE.
- done_o  output  1  one-cycle pulse in DONE state.
- si_o  output  DATA_W  old S[i]. Holds value until next accepted start.
- sj_o  output  DATA_W  old S[j]. Holds value until next accepted start.
- ks_idx_o  output  DATA_W  (si_o + sj_o) mod 2^DATA_W.
- mem_addr_o  output  ADDR_W  SRAM address.
- mem_re_o  output  1  SRAM read strobe.
- mem_we_o  output  1  SRAM write strobe.
- mem_wdata_o  output  DATA_W  SRAM write data.
- mem_rdata_i  input  DATA_W  SRAM read data, valid READ_LAT cycles after the re cycle.

Behaviour:
- Reset (asynchronous, n_rst=0):
  - State goes to IDLE.
  - All outputs and internal registers (latched i/j, si, sj, wait counter) go to 0.
  - No strobe is asserted.
  - Reset mid-operation abandons the swap; a partially complete write sequence is not finished.
- States: IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE.
- IDLE:
  - With start_i=1 at an edge: latch idx_i_i/idx_j_i, go to RD_I.
  - Otherwise stay in IDLE.
  - start_i outside IDLE is ignored, not queued.
- RD_I: mem_re_o=1, mem_addr_o=i for one cycle, then WAIT_I.
- WAIT_I:
  - Lasts READ_LAT cycles, counted by a 2-bit counter.
  - At the final edge: capture mem_rdata_i into si, then go to RD_J.
- RD_J / WAIT_J: same as RD_I / WAIT_I with address j; capture into sj.
- WR_I: mem_we_o=1, mem_addr_o=i, mem_wdata_o=sj for one cycle.
- WR_J: mem_we_o=1, mem_addr_o=j, mem_wdata_o=si for one cycle.
- DONE: done_o=1 for one cycle, then IDLE. busy_o drops the same edge done_o drops.
- Strobe and bus rules:
  - mem_re_o and mem_we_o are never high together.
  - Outside RD/WR states, mem_addr_o and mem_wdata_o hold 0.
- Latency:
  - Accepted start to done_o pulse is 5+2·READ_LAT cycles. READ_LAT=1 gives 7 cycles (RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE).
  - A new start is accepted no earlier than the cycle after DONE.
- Register update rules:
  - si_o/sj_o update only at their capture edges.
  - ks_idx_o is combinational from si/sj and wraps modulo 2^DATA_W with carry discarded.
- i==j: full sequence runs and the same value is written twice. Net memory effect is none.

Optional Feature:
- Macro: SWAP_SAME_SKIP_EN.
- When defined and the latched i equals j:
  - Run RD_I/WAIT_I only.
  - Set sj equal to si at the capture edge.
  - Skip RD_J, WAIT_J, WR_I, WR_J and go straight to DONE.
  - Latency becomes 2+READ_LAT cycles; no write strobe is issued.
- When undefined: i==j follows the full sequence described above.

Test Plan:
- Basic swap: memory preloaded S[3]=0x11, S[7]=0xF0; start i=3, j=7, READ_LAT=1
  - mem_re_o at addr 3 then 7.
  - Writes: (addr 3, data 0xF0), then (addr 7, data 0x11).
  - done_o pulses 7 cycles after start; ks_idx_o=0x01 (wrap).
- Back-to-back: second start held high during the busy window and the DONE cycle
  - Ignored until IDLE.
  - Second swap starts the cycle after DONE; exactly two done_o pulses.
- i==j=0x40, S[0x40]=0x5A
  - Without macro: 7 cycles, two writes of 0x5A to 0x40.
  - With SWAP_SAME_SKIP_EN: 3 cycles, zero writes, si_o=sj_o=0x5A, ks_idx_o=0xB4.
- READ_LAT=3: start i=1, j=2 → done_o at 11 cycles; capture uses data presented 3 cycles after each re.
- Reset mid-op: assert n_rst low during WR_I
  - Strobes drop immediately (asynchronous); all outputs 0.
  - S[j] unchanged in memory; after release, state is IDLE and busy_o=0.
- Strobe exclusivity: over a 50-swap random run, mem_re_o & mem_we_o never both 1, and memory matches the reference permutation model.

Source files
------------

// File: rtl/swap_writer.sv
`default_nettype none
// ============================================================================
//  Module      : swap_writer
//  Description : RC4 S-box swap sequencer. Reads S[i] and S[j], writes them
//                back crossed and exposes the pair plus the keystream index.
//                Optional macro SWAP_SAME_SKIP_EN: when i==j, stop after the
//                first read and skip the writes (swap is a no-op).
//  Revision    : 1.0 - initial release
// ============================================================================
module swap_writer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1    // legal range 1..3
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] idx_i_i,
    input  logic [ADDR_W-1:0] idx_j_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] si_o,
    output logic [DATA_W-1:0] sj_o,
    output logic [DATA_W-1:0] ks_idx_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_I   = 3'd1,
        WAIT_I = 3'd2,
        RD_J   = 3'd3,
        WAIT_J = 3'd4,
        WR_I   = 3'd5,
        WR_J   = 3'd6,
        DONE   = 3'd7
    } state_t;

    // Wait counter value at which the read data is valid on mem_rdata_i.
    localparam logic [1:0] C_LAT_LAST = 2'(READ_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [DATA_W-1:0] si_q, si_d;
    logic [DATA_W-1:0] sj_q, sj_d;
    logic [1:0]        cnt_q, cnt_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        cnt_d       = cnt_q;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        done_o      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    i_d     = idx_i_i;
                    j_d     = idx_j_i;
                    state_d = RD_I;
                end
            end
            RD_I: begin
                mem_re_o   = 1'b1;
                mem_addr_o = i_q;
                cnt_d      = '0;
                state_d    = WAIT_I;
            end
            WAIT_I: begin
                if (cnt_q == C_LAT_LAST) begin
                    si_d  = mem_rdata_i;
                    cnt_d = '0;
`ifdef SWAP_SAME_SKIP_EN
                    if (i_q == j_q) begin
                        sj_d    = mem_rdata_i;
                        state_d = DONE;
                    end else begin
                        state_d = RD_J;
                    end
`else
                    state_d = RD_J;
`endif
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RD_J: begin
                mem_re_o   = 1'b1;
                mem_addr_o = j_q;
                cnt_d      = '0;
                state_d    = WAIT_J;
            end
            WAIT_J: begin
                if (cnt_q == C_LAT_LAST) begin
                    sj_d    = mem_rdata_i;
                    cnt_d   = '0;
                    state_d = WR_I;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            WR_I: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = i_q;
                mem_wdata_o = sj_q;
                state_d     = WR_J;
            end
            WR_J: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = j_q;
                mem_wdata_o = si_q;
                state_d     = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o   = (state_q != IDLE);
    assign si_o     = si_q;
    assign sj_o     = sj_q;
    assign ks_idx_o = si_q + sj_q;

endmodule
`default_nettype wire

// File: tb/tb_swap_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_swap_writer
//  Description : Self-checking bench for swap_writer (READ_LAT=1 and =3
//                instances, each with its own SRAM model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_swap_writer;

`ifdef SWAP_SAME_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int LAT_SAME = SKIP ? 3 : 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst;
    logic       start0, start1;
    logic [7:0] i0, j0, i1, j1;
    logic       busy0, done0, re0, we0, busy1, done1, re1, we1;
    logic [7:0] si0, sj0, ks0, addr0, wdata0, rdata0;
    logic [7:0] si1, sj1, ks1, addr1, wdata1, rdata1;

    swap_writer #(.ADDR_W(8), .DATA_W(8), .READ_LAT(1)) u_dut0 (
        .clk(clk), .n_rst(n_rst), .start_i(start0), .idx_i_i(i0), .idx_j_i(j0),
        .busy_o(busy0), .done_o(done0), .si_o(si0), .sj_o(sj0), .ks_idx_o(ks0),
        .mem_addr_o(addr0), .mem_re_o(re0), .mem_we_o(we0),
        .mem_wdata_o(wdata0), .mem_rdata_i(rdata0)
    );

    swap_writer #(.ADDR_W(8), .DATA_W(8), .READ_LAT(3)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .start_i(start1), .idx_i_i(i1), .idx_j_i(j1),
        .busy_o(busy1), .done_o(done1), .si_o(si1), .sj_o(sj1), .ks_idx_o(ks1),
        .mem_addr_o(addr1), .mem_re_o(re1), .mem_we_o(we1),
        .mem_wdata_o(wdata1), .mem_rdata_i(rdata1)
    );

    // SRAM models: read data is valid only READ_LAT cycles after the re cycle,
    // every other cycle shows a filler value so a mistimed capture is visible.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [8:0] p0;
    logic [8:0] p1 [3];
    logic       bd_we;
    logic [7:0] bd_addr, bd_data;

    always @(posedge clk) begin
        if (bd_we) begin
            mem0[bd_addr] <= bd_data;
            mem1[bd_addr] <= bd_data;
        end else begin
            if (we0) mem0[addr0] <= wdata0;
            if (we1) mem1[addr1] <= wdata1;
        end
        p0    <= {re0, mem0[addr0]};
        p1[0] <= {re1, mem1[addr1]};
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign rdata0 = p0[8]    ? p0[7:0]    : 8'hA5;
    assign rdata1 = p1[2][8] ? p1[2][7:0] : 8'hA5;

    // Bus monitor for instance 0
    logic [7:0] rd_q[$];
    logic [7:0] wa_q[$];
    logic [7:0] wd_q[$];
    int         done_cnt  = 0;
    int         excl_bad  = 0;
    always @(posedge clk) begin
        if (n_rst) begin
            if (re0) rd_q.push_back(addr0);
            if (we0) begin
                wa_q.push_back(addr0);
                wd_q.push_back(wdata0);
            end
            if (done0) done_cnt++;
            if ((re0 && we0) || (re1 && we1)) excl_bad++;
        end
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    string      cur   = "init";
    logic [7:0] ref_mem [256];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %02h, want %02h", cur, name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0b, want %0b", cur, name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0d, want %0d", cur, name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int k);
        case (k)
            8'h03:   return 8'h11;
            8'h07:   return 8'hF0;
            8'h40:   return 8'h5A;
            8'h10:   return 8'h22;
            8'h20:   return 8'h33;
            8'hFF:   return 8'h80;
            8'h00:   return 8'h80;
            default: return 8'(k + 128);
        endcase
    endfunction

    // Issue one swap on instance 0; lat = cycle of done_o (0 on timeout).
    task automatic run_swap(input logic [7:0] i, input logic [7:0] j, output int lat);
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
        i0     = i;
        j0     = j;
        start0 = 1'b1;
        lat    = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) start0 = 1'b0;
            if (done0) begin
                lat = c;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_swap(input logic [7:0] i, input logic [7:0] j,
                              input logic [7:0] e_si, input logic [7:0] e_sj,
                              input logic [7:0] e_ks, input int e_lat);
        int         lat;
        bit         skip;
        logic [7:0] t;
        skip = SKIP && (i == j);
        run_swap(i, j, lat);
        chki("latency", lat, e_lat);
        chk8("si_o", si0, e_si);
        chk8("sj_o", sj0, e_sj);
        chk8("ks_idx_o", ks0, e_ks);
        chk1("busy_after", busy0, 1'b0);
        chki("n_reads", rd_q.size(), skip ? 1 : 2);
        if (rd_q.size() > 0) chk8("rd_addr_i", rd_q[0], i);
        if (!skip && rd_q.size() > 1) chk8("rd_addr_j", rd_q[1], j);
        chki("n_writes", wa_q.size(), skip ? 0 : 2);
        if (!skip && wa_q.size() == 2) begin
            chk8("wr0_addr", wa_q[0], i);
            chk8("wr0_data", wd_q[0], e_sj);
            chk8("wr1_addr", wa_q[1], j);
            chk8("wr1_data", wd_q[1], e_si);
        end
        chk8("mem_i", mem0[i], e_sj);
        chk8("mem_j", mem0[j], e_si);
        t          = ref_mem[i];
        ref_mem[i] = ref_mem[j];
        ref_mem[j] = t;
    endtask

    typedef struct {
        logic [7:0] i, j, si, sj, ks;
        int         lat;
    } vec_t;
    vec_t tbl [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lat, first, second, d0, found, diffs;
        logic [7:0] ri, rj, eks;

        tbl[0] = '{8'h03, 8'h07, 8'h11, 8'hF0, 8'h01, 7};
        tbl[1] = '{8'h40, 8'h40, 8'h5A, 8'h5A, 8'hB4, LAT_SAME};
        tbl[2] = '{8'h10, 8'h20, 8'h22, 8'h33, 8'h55, 7};
        tbl[3] = '{8'h03, 8'h07, 8'hF0, 8'h11, 8'h01, 7};
        tbl[4] = '{8'hFF, 8'h00, 8'h80, 8'h80, 8'h00, 7};

        start0 = 1'b0; start1 = 1'b0;
        i0 = '0; j0 = '0; i1 = '0; j1 = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #2;
        cur = "reset";
        chk1("busy_o", busy0, 1'b0);
        chk1("done_o", done0, 1'b0);
        chk1("mem_re_o", re0, 1'b0);
        chk1("mem_we_o", we0, 1'b0);
        chk8("mem_addr_o", addr0, 8'h00);
        chk8("si_o", si0, 8'h00);
        chk8("ks_idx_o", ks0, 8'h00);
        @(posedge clk);
        @(posedge clk); #2;
        n_rst = 1'b1;
        @(posedge clk); #1;

        bd_we = 1'b1;
        for (int k = 0; k < 256; k++) begin
            bd_addr    = 8'(k);
            bd_data    = init_val(k);
            ref_mem[k] = init_val(k);
            @(posedge clk); #1;
        end
        bd_we = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            cur = $sformatf("vec%0d", v);
            check_swap(tbl[v].i, tbl[v].j, tbl[v].si, tbl[v].sj, tbl[v].ks, tbl[v].lat);
        end

        // READ_LAT=3 instance: S[1]=0x81, S[2]=0x82
        cur = "lat3";
        i1 = 8'h01; j1 = 8'h02; start1 = 1'b1; lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) start1 = 1'b0;
            if (done1) begin
                lat = c;
                break;
            end
        end
        chki("latency", lat, 11);
        chk8("si_o", si1, 8'h81);
        chk8("sj_o", sj1, 8'h82);
        chk8("ks_idx_o", ks1, 8'h03);
        @(posedge clk); #1;
        chk1("busy_after", busy1, 1'b0);
        chk8("mem_1", mem1[1], 8'h82);
        chk8("mem_2", mem1[2], 8'h81);

        // Back-to-back: start held high through busy and DONE
        cur = "b2b";
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        d0 = done_cnt; first = 0; second = 0;
        i0 = 8'h30; j0 = 8'h31; start0 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                i0 = 8'h32;
                j0 = 8'h33;
            end
            if (first != 0 && c == first + 1) chk1("idle_gap_busy", busy0, 1'b0);
            if (first != 0 && c == first + 2) start0 = 1'b0;
            if (done0) begin
                if (first == 0) begin
                    first = c;
                    chk1("busy_in_done", busy0, 1'b1);
                end else begin
                    second = c;
                    break;
                end
            end
        end
        start0 = 1'b0;
        @(posedge clk); #1;
        chki("first_done", first, 7);
        chki("second_done", second, 15);
        chki("done_pulses", done_cnt - d0, 2);
        chki("n_reads", rd_q.size(), 4);
        chki("n_writes", wa_q.size(), 4);
        if (rd_q.size() == 4) begin
            chk8("rd2", rd_q[2], 8'h32);
            chk8("rd3", rd_q[3], 8'h33);
        end
        if (wa_q.size() == 4) begin
            chk8("wd0", wd_q[0], 8'hB1);
            chk8("wd1", wd_q[1], 8'hB0);
            chk8("wa2", wa_q[2], 8'h32);
            chk8("wd3", wd_q[3], 8'hB2);
        end
        chk8("si_o", si0, 8'hB2);
        chk8("sj_o", sj0, 8'hB3);
        ref_mem[8'h30] = 8'hB1; ref_mem[8'h31] = 8'hB0;
        ref_mem[8'h32] = 8'hB3; ref_mem[8'h33] = 8'hB2;

        // Random swaps against the permutation reference
        for (int n = 0; n < 50; n++) begin
            cur = $sformatf("rand%0d", n);
            ri  = 8'($urandom_range(0, 255));
            rj  = 8'($urandom_range(0, 255));
            if (n % 8 == 0) rj = ri;
            eks = ref_mem[ri] + ref_mem[rj];
            check_swap(ri, rj, ref_mem[ri], ref_mem[rj], eks,
                       (SKIP && ri == rj) ? 3 : 7);
        end

        // Reset during WR_I abandons the swap
        cur = "rst_mid";
        i0 = 8'h50; j0 = 8'h60; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        found  = 0;
        for (int c = 0; c < 20; c++) begin
            if (we0) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chki("reached_wr", found, 1);
        chk8("wr_i_addr", addr0, 8'h50);
        n_rst = 1'b0;
        #1;
        chk1("we_dropped", we0, 1'b0);
        chk1("re_low", re0, 1'b0);
        chk1("busy_low", busy0, 1'b0);
        chk8("addr_zero", addr0, 8'h00);
        chk8("wdata_zero", wdata0, 8'h00);
        chk8("si_zero", si0, 8'h00);
        chk8("sj_zero", sj0, 8'h00);
        @(posedge clk); #2;
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk1("busy_after_rel", busy0, 1'b0);
        chk8("mem_i_kept", mem0[8'h50], ref_mem[8'h50]);
        chk8("mem_j_kept", mem0[8'h60], ref_mem[8'h60]);
        eks = ref_mem[8'h50] + ref_mem[8'h60];
        cur = "after_rst";
        check_swap(8'h50, 8'h60, ref_mem[8'h50], ref_mem[8'h60], eks, 7);

        cur   = "final";
        diffs = 0;
        for (int k = 0; k < 256; k++)
            if (mem0[k] !== ref_mem[k]) diffs++;
        chki("mem_vs_ref", diffs, 0);
        chki("re_we_exclusive", excl_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
